// File: rtl/mac_rr_sched.sv
// mac_rr_sched: two-client round-robin scheduler in front of one shared
// 4x4-bit multiply-accumulate unit. A granted client streams len+1 operand
// pairs; the block returns their 12-bit dot product with the client index.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   req0/req1            level job request per client
//   len0/len1            job length minus one, sampled at grant
//   a0/b0, a1/b1         unsigned operand pairs per client
//   vld0/vld1            operand-pair valid per client
//   gnt                  one-hot registered grant (01 = client 0)
//   busy                 high whenever the FSM is not idle
//   out, out_id          registered result and its client index
//   out_valid            one-cycle result strobe
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here only
// RUN   | accepting operand pairs from the granted client
// DRAIN | last product is being added into the accumulator
// OUT   | result is registered to the outputs on leaving this state
module mac_rr_sched #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [3:0]       a0,
    input  logic [3:0]       b0,
    input  logic [3:0]       a1,
    input  logic [3:0]       b1,
    input  logic             vld0,
    input  logic             vld1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [11:0]      out,
    output logic             out_id,
    output logic             out_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             ptr_q, ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [11:0]      acc_q, acc_d;
    logic [7:0]       prod_q, prod_d;
    logic             prod_v_q, prod_v_d;
    logic [11:0]      out_q, out_d;
    logic             out_id_q, out_id_d;
    logic             out_valid_q, out_valid_d;

    logic             pick1;
    logic             sel_vld;
    logic [3:0]       sel_a;
    logic [3:0]       sel_b;

    // Operand mux follows the registered grant, so the idle client never
    // reaches the multiplier.
    assign sel_vld = gnt_q[1] ? vld1 : vld0;
    assign sel_a   = gnt_q[1] ? a1   : a0;
    assign sel_b   = gnt_q[1] ? b1   : b0;

    // Pointer only breaks ties; a lone requester always wins.
    assign pick1   = (req0 && req1) ? ptr_q : req1;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_v_d    = 1'b0;
        out_d       = out_q;
        out_id_d    = out_id_q;
        out_valid_d = 1'b0;

        // Second pipeline stage runs in any state; the last add lands in DRAIN.
        if (prod_v_q) begin
            acc_d = acc_q + {4'd0, prod_q};
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    len_d   = pick1 ? len1 : len0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sel_vld) begin
                    prod_d   = {4'd0, sel_a} * {4'd0, sel_b};
                    prod_v_d = 1'b1;
                    if (cnt_q == len_q) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            DRAIN: begin
                state_d = OUT;
            end
            OUT: begin
                out_d       = acc_q;
                out_id_d    = gnt_q[1];
                out_valid_d = 1'b1;
                gnt_d       = 2'b00;
                ptr_d       = ~gnt_q[1];
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            ptr_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            out_q       <= '0;
            out_id_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            out_q       <= out_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign out_id    = out_id_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_rr_sched.sv
// tb_mac_rr_sched: directed scenarios plus a random phase, checked every
// cycle against a job-level model of the scheduler.
module tb_mac_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [3:0]  len0 = '0, len1 = '0;
    logic [3:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        vld0 = 1'b0, vld1 = 1'b0;
    logic [1:0]  gnt;
    logic        busy;
    logic [11:0] out;
    logic        out_id;
    logic        out_valid;

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    mac_rr_sched #(.LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .len0(len0), .len1(len1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .vld0(vld0), .vld1(vld1),
        .gnt(gnt), .busy(busy),
        .out(out), .out_id(out_id), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: a job owns the MAC from grant until its result is
    // posted two edges after the final accepted pair.
    bit         m_busy = 0, m_who = 0, m_ptr = 0, m_ov = 0, m_oid = 0;
    logic [1:0] m_gnt = 2'b00;
    int         m_left = 0, m_wait = 0, m_sum = 0, m_out = 0;

    task automatic model_reset();
        m_busy = 0; m_who = 0; m_ptr = 0; m_ov = 0; m_oid = 0;
        m_gnt = 2'b00; m_left = 0; m_wait = 0; m_sum = 0; m_out = 0;
    endtask

    task automatic model_step();
        m_ov = 0;
        if (!m_busy) begin
            if (req0 || req1) begin
                m_who  = (req0 && req1) ? m_ptr : req1;
                m_gnt  = m_who ? 2'b10 : 2'b01;
                m_left = (m_who ? int'(len1) : int'(len0)) + 1;
                m_sum  = 0;
                m_wait = 0;
                m_busy = 1;
            end
        end else if (m_left > 0) begin
            if (m_who ? vld1 : vld0) begin
                m_sum += m_who ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
                m_left--;
                if (m_left == 0) m_wait = 2;
            end
        end else begin
            m_wait--;
            if (m_wait == 0) begin
                m_out  = m_sum;
                m_oid  = m_who;
                m_ov   = 1;
                m_gnt  = 2'b00;
                m_busy = 0;
                m_ptr  = !m_who;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt", gnt, m_gnt);
            chk("busy", busy, m_busy);
            chk("out_valid", out_valid, m_ov);
            chk("out", out, m_out);
            chk("out_id", out_id, m_oid);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_result(output logic [11:0] o, output logic id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 400);
        chk("result_timeout", (n < 400), 1);
        o  = out;
        id = out_id;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [11:0] r_out;
    logic        r_id;
    logic [3:0]  ta [4] = '{4'd2, 4'd4, 4'd15, 4'd1};
    logic [3:0]  tb [4] = '{4'd3, 4'd5, 4'd15, 4'd1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out", out, 0);
        chk("rst_valid", out_valid, 0);
        #2 rst_n = 1'b1;
        tick();

        // Single client, four back-to-back pairs.
        req0 = 1; len0 = 4'd3;
        tick();
        chk("s1_gnt", gnt, 2'b01);
        req0 = 0;
        for (int i = 0; i < 4; i++) begin
            a0 = ta[i]; b0 = tb[i]; vld0 = 1;
            tick();
        end
        vld0 = 0;
        tick();
        chk("s1_valid_t1", out_valid, 0);
        tick();
        chk("s1_valid_t2", out_valid, 1);
        chk("s1_out", out, 252);
        chk("s1_id", out_id, 0);
        tick();
        chk("s1_valid_t3", out_valid, 0);
        chk("s1_hold", out, 252);

        // Both clients requesting from reset release.
        req0 = 1; req1 = 1; len0 = 0; len1 = 0;
        a0 = 3; b0 = 3; a1 = 7; b1 = 2; vld0 = 1; vld1 = 1;
        do_reset();
        chk("s2_gnt0", gnt, 2'b01);
        wait_result(r_out, r_id);
        chk("s2_out0", r_out, 9);
        chk("s2_id0", r_id, 0);
        tick();
        chk("s2_gnt1", gnt, 2'b10);
        wait_result(r_out, r_id);
        chk("s2_out1", r_out, 14);
        chk("s2_id1", r_id, 1);
        req0 = 0; req1 = 0; vld0 = 0; vld1 = 0;

        // Long job with random valid gaps and idle-client noise.
        do_reset();
        req1 = 1; len1 = 4'd15; a1 = 15; b1 = 15;
        tick();
        chk("s3_gnt", gnt, 2'b10);
        req1 = 0;
        for (int n = 0; n < 400 && !out_valid; n++) begin
            vld1 = 1'($urandom_range(0, 1));
            vld0 = 1'($urandom_range(0, 1));
            a0 = 4'($urandom); b0 = 4'($urandom);
            tick();
        end
        chk("s3_seen", out_valid, 1);
        chk("s3_out", out, 3600);
        chk("s3_id", out_id, 1);
        vld0 = 0; vld1 = 0;

        // Client 0 job with req0 dropped and client 1 toggling garbage.
        req0 = 1; len0 = 4'($urandom);
        tick();
        tick();
        req0 = 0;
        for (int n = 0; n < 400 && !out_valid; n++) begin
            vld0 = 1'($urandom_range(0, 1));
            a0 = 4'($urandom); b0 = 4'($urandom);
            vld1 = 1'($urandom_range(0, 1));
            a1 = 4'($urandom); b1 = 4'($urandom);
            tick();
        end
        chk("s4_seen", out_valid, 1);
        chk("s4_id", out_id, 0);
        vld0 = 0; vld1 = 0;
        repeat (2) tick();

        // Reset in the middle of a job.
        req0 = 1; len0 = 4'd3;
        tick();
        req0 = 0;
        a0 = 5; b0 = 5; vld0 = 1;
        tick();
        a0 = 6; b0 = 6;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("s5_gnt", gnt, 0);
        chk("s5_busy", busy, 0);
        chk("s5_out", out, 0);
        chk("s5_id", out_id, 0);
        chk("s5_valid", out_valid, 0);
        vld0 = 0;
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();
        req0 = 1; req1 = 1; len0 = 0; len1 = 0;
        a0 = 2; b0 = 7; vld0 = 1; a1 = 9; b1 = 9; vld1 = 1;
        tick();
        chk("s5_prio", gnt, 2'b01);
        req0 = 0; req1 = 0;
        wait_result(r_out, r_id);
        chk("s5_out_new", r_out, 14);
        chk("s5_id_new", r_id, 0);
        vld0 = 0; vld1 = 0;

        // Fully random traffic.
        for (int n = 0; n < 600; n++) begin
            req0 = ($urandom_range(0, 3) == 0);
            req1 = ($urandom_range(0, 3) == 0);
            len0 = 4'($urandom_range(0, 5));
            len1 = 4'($urandom_range(0, 5));
            a0 = 4'($urandom); b0 = 4'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom);
            vld0 = 1'($urandom_range(0, 1));
            vld1 = 1'($urandom_range(0, 1));
            tick();
        end
        req0 = 0; req1 = 0; vld0 = 0; vld1 = 0;
        repeat (60) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
